cordic_vector_seq: RTL and testbench

Operand sequencer and result capture stage sitting directly upstream of the 13-iteration vectoring CORDIC (TAN/ROOT engine). The CORDIC has no start/done handshake and free-runs 14-cycle frames at an unknown phase. This block accepts requests over valid/ready, holds X_IN/Y_IN/FUNC stable long enough that one complete frame uses them, then captures the matching TAN or ROOT. It returns each result with a function tag over valid/ready.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_req_fifo.sv | 73 +++++++
 rtl/cordic_vector_seq.sv | 136 +++++++++++++
 tb/tb_cordic_vector_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, request record and FSM state type for the vectoring-CORDIC operand sequencer.
package cordic_pkg;

    localparam int FRAME_CYCLES = 14;
    localparam int HOLD_CYCLES  = 2 * FRAME_CYCLES + 1;
    localparam int OPERAND_W    = 7;
    localparam int RESULT_W     = 16;

    typedef struct packed {
        logic [OPERAND_W-1:0] x;
        logic [OPERAND_W-1:0] y;
        logic                 func;
    } req_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/cordic_req_fifo.sv
// Request queue: first-word-fall-through ring buffer, or a single holding register when DEPTH is 1.
module cordic_req_fifo
    import cordic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  logic i_pop,
    input  req_t i_data,
    output req_t o_data,
    output logic o_empty,
    output logic o_full
);

    generate
        if (DEPTH == 1) begin : g_reg
            req_t r_data;
            logic r_valid;

            // NOTE: non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else if (i_push) begin
                    r_data  <= i_data;
                    r_valid <= 1'b1;
                end else if (i_pop) begin
                    r_valid <= 1'b0;
                end
            end

            assign o_data  = r_data;
            assign o_empty = !r_valid;
            assign o_full  = r_valid;
        end else begin : g_ring
            localparam int AW = $clog2(DEPTH);

            req_t            r_mem [DEPTH];
            logic [AW-1:0]   r_wr_ptr;
            logic [AW-1:0]   r_rd_ptr;
            logic [AW:0]     r_count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                    case ({i_push, i_pop})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            // NOTE: storage is not reset; the pointers and count alone define valid contents.
            always_ff @(posedge clk) begin
                if (i_push) r_mem[r_wr_ptr] <= i_data;
            end

            assign o_data  = r_mem[r_rd_ptr];
            assign o_empty = (r_count == '0);
            assign o_full  = (r_count == (AW + 1)'(DEPTH));
        end
    endgenerate

endmodule

// File: rtl/cordic_vector_seq.sv
// Holds operands for a free-running 14-cycle CORDIC long enough to span one full frame, then captures TAN/ROOT.
// Build option: CORDIC_SEQ_FIFO_EN selects a FIFO_DEPTH-entry request FIFO instead of a single request register.
module cordic_vector_seq
    import cordic_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [OPERAND_W-1:0]       req_x,
    input  logic [OPERAND_W-1:0]       req_y,
    input  logic                       req_func,
    output logic [OPERAND_W-1:0]       cx,
    output logic [OPERAND_W-1:0]       cy,
    output logic                       cfunc,
    input  logic signed [RESULT_W-1:0] tan_in,
    input  logic signed [RESULT_W-1:0] root_in,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [RESULT_W-1:0] res_data,
    output logic                       res_func,
    output logic                       busy
);

    localparam int               CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

`ifdef CORDIC_SEQ_FIFO_EN
    localparam int REQ_DEPTH = FIFO_DEPTH;
`else
    // Single holding register; FIFO_DEPTH only sizes the optional FIFO, so it reduces to 1 here.
    localparam int REQ_DEPTH = FIFO_DEPTH / FIFO_DEPTH;
`endif

    state_e                       r_state;
    state_e                       w_state_next;
    logic [CNT_W-1:0]             r_cnt;
    logic [OPERAND_W-1:0]         r_cx;
    logic [OPERAND_W-1:0]         r_cy;
    logic                         r_cfunc;
    logic                         r_res_valid;
    logic signed [RESULT_W-1:0]   r_res_data;
    logic                         r_res_func;

    req_t w_req;
    req_t w_head;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_slot_free;
    logic w_launch;
    logic w_capture;

    assign w_req       = '{x: req_x, y: req_y, func: req_func};
    assign w_slot_free = !r_res_valid || res_ready;
    assign w_launch    = (r_state == IDLE) && !w_empty && w_slot_free;
    assign w_capture   = (r_state == HOLD) && (r_cnt == CNT_LAST);

`ifdef CORDIC_SEQ_FIFO_EN
    assign req_ready = !w_full;
`else
    assign req_ready = !w_full || w_launch;
`endif
    assign w_push = req_valid && req_ready;

    cordic_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk     (CLK),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_launch),
        .i_data  (w_req),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: default assigned first so no path through this block leaves a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_launch)  w_state_next = HOLD;
            HOLD:    if (w_capture) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_cfunc     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_func  <= 1'b0;
        end else begin
            if (w_launch) begin
                r_cx    <= w_head.x;
                r_cy    <= w_head.y;
                r_cfunc <= w_head.func;
                r_cnt   <= '0;
            end else if (w_capture) begin
                r_cnt <= '0;
            end else if (r_state == HOLD) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // A capture wins over a same-edge accept so the fresh result is never dropped.
            if (w_capture) begin
                r_res_data  <= r_cfunc ? root_in : tan_in;
                r_res_func  <= r_cfunc;
                r_res_valid <= 1'b1;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign cx        = r_cx;
    assign cy        = r_cy;
    assign cfunc     = r_cfunc;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_func  = r_res_func;
    assign busy      = (r_state == HOLD);

endmodule

// File: tb/tb_cordic_vector_seq.sv
// Directed bench for cordic_vector_seq with a phase-randomised stub CORDIC and an in-order result scoreboard.
module tb_cordic_vector_seq;

`ifdef CORDIC_SEQ_FIFO_EN
    localparam int QD = 4;
`else
    localparam int QD = 1;
`endif

    typedef struct {
        logic        f;
        logic [15:0] d;
    } exp_t;

    logic               CLK = 1'b0;
    logic               reset = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [6:0]         req_x = '0;
    logic [6:0]         req_y = '0;
    logic               req_func = 1'b0;
    logic [6:0]         cx;
    logic [6:0]         cy;
    logic               cfunc;
    logic signed [15:0] tan_in = '0;
    logic signed [15:0] root_in = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic signed [15:0] res_data;
    logic               res_func;
    logic               busy;

    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;
    int   cyc    = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    cordic_vector_seq #(.FIFO_DEPTH(4)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_func  (req_func),
        .cx        (cx),
        .cy        (cy),
        .cfunc     (cfunc),
        .tan_in    (tan_in),
        .root_in   (root_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_func  (res_func),
        .busy      (busy)
    );

    // Stub CORDIC: loads operands on the first cycle of a frame, publishes on the last.
    int unsigned st_fc = $urandom_range(13, 0);
    logic [6:0]  st_x = '0;
    logic [6:0]  st_y = '0;
    logic        st_f = 1'b0;

    always @(posedge CLK) begin
        if (st_fc == 0) begin
            st_x <= cx;
            st_y <= cy;
            st_f <= cfunc;
        end
        if (st_fc == 13) begin
            if (st_f) root_in <= {9'b0, st_x};
            else      tan_in  <= {9'b0, st_y};
        end
        st_fc <= (st_fc == 13) ? 0 : st_fc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (reset && res_valid && res_ready) begin
            exp_t e;
            check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_res_data", 32'(unsigned'(res_data)), 32'(e.d));
                check("sb_res_func", 32'(res_func), 32'(e.f));
                popped++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [6:0] x, input logic [6:0] y, input logic f, output int e);
        int n;
        n = 0;
        #1;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        check("req_ready_before_send", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_func  = f;
        @(posedge CLK);
        #1;
        e         = cyc;
        req_valid = 1'b0;
        sb.push_back('{f, f ? {9'b0, x} : {9'b0, y}});
        pushed++;
    endtask

    task automatic wait_res(input string tag, output int c);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        check(tag, 32'(res_valid), 32'd1);
        c = cyc;
    endtask

    initial begin
        int e, c, c2, l, n;

        // Reset state
        #2 reset = 1'b0;
        #20;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_cx_cy_cfunc", {17'b0, cx, cy, cfunc}, 32'd0);
        check("rst_res_data_func", {15'b0, res_func, res_data}, 32'd0);
        #10 reset = 1'b1;
        tick();

        // Single ROOT request swept across every stub frame phase
        res_ready = 1'b1;
        for (int p = 0; p < 14; p++) begin
            n = 0;
            while (st_fc != p && n < 20) begin
                tick();
                n++;
            end
            send(7'd5, 7'd3, 1'b1, e);
            tick();
            check("launch_busy", 32'(busy), 32'd1);
            check("launch_cx_cfunc", {24'b0, cx, cfunc}, {24'b0, 7'd5, 1'b1});
            wait_res("single_res_valid", c);
            check("single_latency", 32'(c - e), 32'd30);
            check("single_res_data", 32'(unsigned'(res_data)), 32'd5);
            check("single_res_func", 32'(res_func), 32'd1);
            tick();
            tick();
        end

        // ROOT then TAN back-to-back
        send(7'd7, 7'd9, 1'b1, e);
        send(7'd0, 7'd100, 1'b0, l);
        check("b2b_accept_spacing", 32'(l - e), 32'd1);
        wait_res("b2b_first_valid", c);
        check("b2b_first_latency", 32'(c - e), 32'd30);
        check("b2b_first_data", 32'(unsigned'(res_data)), 32'd7);
        check("b2b_first_func", 32'(res_func), 32'd1);
        tick();
        wait_res("b2b_second_valid", c2);
        check("b2b_capture_gap", 32'(c2 - c), 32'd30);
        check("b2b_second_data", 32'(unsigned'(res_data)), 32'd100);
        check("b2b_second_func", 32'(res_func), 32'd0);
        tick();
        tick();

        // Queue build-up with the consumer stalled
        res_ready = 1'b0;
        send(7'd1, 7'd2, 1'b0, e);
        tick();
        check("fill_first_launch", 32'(busy), 32'd1);
        for (int i = 0; i < QD; i++) begin
            send(7'(i + 3), 7'(i + 20), i[0], l);
        end
        check("fill_req_ready_low", 32'(req_ready), 32'd0);
        wait_res("fill_first_valid", c);
        check("fill_first_latency", 32'(c - e), 32'd30);
        repeat (35) tick();
        check("fill_no_second_launch", 32'(busy), 32'd0);
        check("fill_res_held", 32'(res_valid), 32'd1);
        check("fill_res_data_held", 32'(unsigned'(res_data)), 32'd2);
        check("fill_still_full", 32'(req_ready), 32'd0);
        res_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("fill_drained", 32'(sb.size()), 32'd0);
        tick();
        tick();
        check("fill_idle_after", {30'b0, busy, res_valid}, 32'd0);

        // Result accept and capture landing on the same edge
        res_ready = 1'b0;
        send(7'd1, 7'd11, 1'b0, e);
        wait_res("edge_a_valid", c);
        check("edge_a_data", 32'(unsigned'(res_data)), 32'd11);
        send(7'd3, 7'd33, 1'b1, e);
        res_ready = 1'b1;
        tick();
        l = cyc;
        res_ready = 1'b0;
        check("edge_b_launched", 32'(busy), 32'd1);
        check("edge_a_cleared", 32'(res_valid), 32'd0);
        n = 0;
        while (cyc < l + 28 && n < 40) begin
            tick();
            n++;
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("edge_capture_cycle", 32'(cyc - l), 32'd29);
        check("edge_b_valid", 32'(res_valid), 32'd1);
        check("edge_b_data", 32'(unsigned'(res_data)), 32'd3);
        check("edge_b_func", 32'(res_func), 32'd1);
        repeat (3) tick();
        check("edge_b_still_valid", 32'(res_valid), 32'd1);
        check("edge_no_dup_or_loss", 32'(popped), 32'(pushed - 1));
        res_ready = 1'b1;
        tick();
        tick();
        check("edge_drained", 32'(sb.size()), 32'd0);
        check("edge_res_cleared", 32'(res_valid), 32'd0);

        // Reset in the middle of HOLD
        send(7'd6, 7'd4, 1'b1, e);
        repeat (13) tick();
        check("mid_hold_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        void'(sb.pop_back());
        pushed--;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_cx_cy_cfunc", {17'b0, cx, cy, cfunc}, 32'd0);
        check("mid_rst_res_data_func", {15'b0, res_func, res_data}, 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        #20 reset = 1'b1;
        tick();
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        send(7'd2, 7'd2, 1'b1, e);
        wait_res("post_rst_valid", c);
        check("post_rst_latency", 32'(c - e), 32'd30);
        check("post_rst_data", 32'(unsigned'(res_data)), 32'd2);
        tick();
        tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
